// File: rtl/iir_freq_resp_capture_if.sv
// Sample stream from the frequency-response evaluator plus the buffer read port.
// The producer/reader side is master; the capture block is slave.
interface iir_freq_resp_capture_if #(
    parameter int CORDIC_XY_BITS    = 16,
    parameter int CORDIC_PHASE_BITS = 16,
    parameter int ADDR_BITS         = 11
);
    logic [CORDIC_XY_BITS-1:0]    tf_val_magnitude;
    logic [CORDIC_PHASE_BITS-1:0] tf_val_phase;
    logic                         tf_val_valid;
    logic                         rd_en;
    logic [ADDR_BITS-1:0]         rd_addr;
    logic [CORDIC_XY_BITS-1:0]    rd_magnitude;
    logic [CORDIC_PHASE_BITS-1:0] rd_phase;
    logic                         rd_valid;

    modport master (
        output tf_val_magnitude, tf_val_phase, tf_val_valid,
        output rd_en, rd_addr,
        input  rd_magnitude, rd_phase, rd_valid
    );

    modport slave (
        input  tf_val_magnitude, tf_val_phase, tf_val_valid,
        input  rd_en, rd_addr,
        output rd_magnitude, rd_phase, rd_valid
    );
endinterface

// File: rtl/iir_freq_resp_capture.sv
// Captures one magnitude/phase sample per bin after the evaluator pipeline fill,
// tracks notch and peak, and serves the buffer through a 1-cycle read port.
module iir_freq_resp_capture #(
    parameter int CORDIC_XY_BITS    = 16,
    parameter int CORDIC_PHASE_BITS = 16,
    parameter int CONFIG_SIZE       = 16,
    parameter int FREQ_VEC_LENGTH   = 1275,
    parameter int ADDR_BITS         = 11,
    parameter int LATENCY           = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CONFIG_SIZE-1:0]    config_nfft,
    input  logic                      start,
    iir_freq_resp_capture_if.slave    bus,
    output logic                      capture_busy,
    output logic                      capture_done,
    output logic                      cfg_err,
    output logic [CONFIG_SIZE-1:0]    bins_captured,
    output logic [CORDIC_XY_BITS-1:0] min_mag,
    output logic [CONFIG_SIZE-1:0]    min_bin,
    output logic [CORDIC_XY_BITS-1:0] max_mag,
    output logic [CONFIG_SIZE-1:0]    max_bin
);

    localparam int DW = CORDIC_XY_BITS + CORDIC_PHASE_BITS;
    localparam logic [CONFIG_SIZE-1:0] NMAX = CONFIG_SIZE'(FREQ_VEC_LENGTH);
    localparam logic [CONFIG_SIZE-1:0] SKIP_LAST =
        CONFIG_SIZE'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;

    state_t                    state;
    logic [CONFIG_SIZE-1:0]    nfft_l;
    logic [CONFIG_SIZE-1:0]    skip_cnt;
    logic [DW-1:0]             mem [FREQ_VEC_LENGTH];
    logic                      active;
    logic                      wr_en;
    logic                      rd_ok;
    logic [CORDIC_XY_BITS-1:0] mag;

    assign active = (state == SKIP) || (state == CAPTURE);
    assign wr_en  = (state == CAPTURE) && bus.tf_val_valid && !rst;
    assign rd_ok  = bus.rd_en && !active;
    assign mag    = bus.tf_val_magnitude;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            nfft_l        <= '0;
            skip_cnt      <= '0;
            capture_busy  <= 1'b0;
            capture_done  <= 1'b0;
            cfg_err       <= 1'b0;
            bins_captured <= '0;
            min_mag       <= '1;
            min_bin       <= '0;
            max_mag       <= '0;
            max_bin       <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        nfft_l        <= (config_nfft > NMAX) ? NMAX : config_nfft;
                        skip_cnt      <= '0;
                        bins_captured <= '0;
                        min_mag       <= '1;
                        min_bin       <= '0;
                        max_mag       <= '0;
                        max_bin       <= '0;
                        if (config_nfft == '0) begin
                            state        <= DONE;
                            cfg_err      <= 1'b1;
                            capture_done <= 1'b1;
                            capture_busy <= 1'b0;
                        end else begin
                            state        <= (LATENCY == 0) ? CAPTURE : SKIP;
                            cfg_err      <= 1'b0;
                            capture_done <= 1'b0;
                            capture_busy <= 1'b1;
                        end
                    end
                end
                SKIP: begin
                    if (bus.tf_val_valid) begin
                        if (skip_cnt == SKIP_LAST) state <= CAPTURE;
                        else skip_cnt <= skip_cnt + CONFIG_SIZE'(1);
                    end
                end
                CAPTURE: begin
                    if (bus.tf_val_valid) begin
                        bins_captured <= bins_captured + CONFIG_SIZE'(1);
                        if (mag < min_mag) begin
                            min_mag <= mag;
                            min_bin <= bins_captured;
                        end
                        if (mag > max_mag) begin
                            max_mag <= mag;
                            max_bin <= bins_captured;
                        end
                        // Last bin: statistics above already include this sample
                        if ((bins_captured + CONFIG_SIZE'(1)) == nfft_l) begin
                            state        <= DONE;
                            capture_busy <= 1'b0;
                            capture_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[bins_captured[ADDR_BITS-1:0]] <= {mag, bus.tf_val_phase};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_valid     <= 1'b0;
            bus.rd_magnitude <= '0;
            bus.rd_phase     <= '0;
        end else begin
            bus.rd_valid <= rd_ok;
            if (rd_ok) begin
                // Bins beyond the latched length read back as zero
                if (CONFIG_SIZE'(bus.rd_addr) >= nfft_l)
                    {bus.rd_magnitude, bus.rd_phase} <= '0;
                else
                    {bus.rd_magnitude, bus.rd_phase} <= mem[bus.rd_addr];
            end
        end
    end

endmodule
